// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings and helper functions for the 5-stage RV32 hazard controller.
package hazard_ctrl_pkg;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_REDIRECT = 2'b10
    } state_t;

    // M is checked first because it holds the younger value of a register also written by W.
    function automatic logic [1:0] fwd_select(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        logic [1:0] sel;
        if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = FWD_M;
        end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = FWD_W;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    function automatic logic load_use(
        input logic [1:0] res_src,
        input logic [4:0] rd_e,
        input logic [4:0] rs1_d,
        input logic [4:0] rs2_d
    );
        return (res_src == RES_MEM) && (rd_e != 5'd0) &&
               ((rd_e == rs1_d) || (rd_e == rs2_d));
    endfunction

endpackage

// File: rtl/hazard_ctrl_forward_unit.sv
// Combinational operand-forwarding selects for both E-stage source operands.
module forward_unit
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs1_e,
    input  logic [4:0] rs2_e,
    input  logic [4:0] rd_m,
    input  logic       reg_write_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_w,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    // Operand A and B use the same priority rule against different source registers.
    always_comb begin
        fwd_a = fwd_select(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
        fwd_b = fwd_select(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing controller: forwarding, stall/flush control, memory watchdog, counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned BR_PENALTY  = 0,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       RS1_D,
    input  logic [4:0]       RS2_D,
    input  logic [4:0]       RS1_E,
    input  logic [4:0]       RS2_E,
    input  logic [4:0]       RD_E,
    input  logic             RegWriteE,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic [4:0]       RD_M,
    input  logic             RegWriteM,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    input  logic [4:0]       RD_W,
    input  logic             RegWriteW,
    input  logic             cnt_clr,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned      WAIT_W   = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_ZERO = {WAIT_W{1'b0}};
    localparam logic [2:0]        PEN_LOAD = 3'(BR_PENALTY);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};

    state_t            state_r;
    state_t            state_s;
    logic [2:0]        pen_r;
    logic [2:0]        pen_s;
    logic [WAIT_W-1:0] wait_r;
    logic [WAIT_W-1:0] wait_s;
    logic              mem_err_r;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic [CNT_W-1:0]  flush_cnt_r;

    logic       mw_s;
    logic       lw_hz_s;
    logic       stall_all_s;
    logic       stall_fd_s;
    logic       flush_d_s;
    logic       flush_e_s;
    logic       br_take_s;
    logic       err_set_s;
    logic [1:0] fwd_a_s;
    logic [1:0] fwd_b_s;

    // RegWriteE is part of the stage interface; the load-use rule keys on ResultSrcE alone.
    logic unused_ok_s;
    assign unused_ok_s = RegWriteE;

    forward_unit u_fwd (
        .rs1_e       (RS1_E),
        .rs2_e       (RS2_E),
        .rd_m        (RD_M),
        .reg_write_m (RegWriteM),
        .rd_w        (RD_W),
        .reg_write_w (RegWriteW),
        .fwd_a       (fwd_a_s),
        .fwd_b       (fwd_b_s)
    );

    assign mw_s    = MemReqM & ~MemReadyM;
    assign lw_hz_s = load_use(ResultSrcE, RD_E, RS1_D, RS2_D);

    // Next-state and stall/flush decode; memory wait always outranks redirect and load-use.
    always_comb begin
        state_s     = state_r;
        pen_s       = pen_r;
        wait_s      = wait_r;
        stall_all_s = 1'b0;
        stall_fd_s  = 1'b0;
        flush_d_s   = 1'b0;
        flush_e_s   = 1'b0;
        br_take_s   = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (mw_s) begin
                    state_s     = ST_MEM_WAIT;
                    stall_all_s = 1'b1;
                    wait_s      = WAIT_ONE;
                end else if (PCSrcE) begin
                    flush_d_s = 1'b1;
                    flush_e_s = 1'b1;
                    br_take_s = 1'b1;
                    if (PEN_LOAD != 3'd0) begin
                        pen_s   = PEN_LOAD;
                        state_s = ST_REDIRECT;
                    end else begin
                        pen_s   = 3'd0;
                    end
                end else if (lw_hz_s) begin
                    stall_fd_s = 1'b1;
                    flush_e_s  = 1'b1;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (mw_s) begin
                    stall_all_s = 1'b1;
                    if (wait_r == WAIT_MAX) begin
                        wait_s = wait_r;
                    end else begin
                        wait_s = wait_r + WAIT_ONE;
                    end
                end else begin
                    // Release cycle: hazards pending behind the wait are re-evaluated next cycle.
                    wait_s  = WAIT_ZERO;
                    state_s = ST_RUN;
                end
            end
            ST_REDIRECT: begin
                if (mw_s) begin
                    state_s     = ST_MEM_WAIT;
                    stall_all_s = 1'b1;
                    wait_s      = WAIT_ONE;
                    pen_s       = 3'd0;
                end else if (PCSrcE) begin
                    flush_d_s = 1'b1;
                    flush_e_s = 1'b1;
                    br_take_s = 1'b1;
                    pen_s     = PEN_LOAD;
                end else begin
                    flush_d_s = 1'b1;
                    if (pen_r <= 3'd1) begin
                        pen_s   = 3'd0;
                        state_s = ST_RUN;
                    end else begin
                        pen_s   = pen_r - 3'd1;
                    end
                end
            end
            default: begin
                state_s = ST_RUN;
                pen_s   = 3'd0;
                wait_s  = WAIT_ZERO;
            end
        endcase
    end

    assign err_set_s = stall_all_s & (wait_s >= WAIT_MAX);

    // FSM, penalty and wait counter state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_RUN;
            pen_r   <= 3'd0;
            wait_r  <= WAIT_ZERO;
        end else begin
            state_r <= state_s;
            pen_r   <= pen_s;
            wait_r  <= wait_s;
        end
    end

    // Saturating performance counters and sticky timeout flag; clear beats increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_r <= CNT_ZERO;
            flush_cnt_r <= CNT_ZERO;
            mem_err_r   <= 1'b0;
        end else if (cnt_clr) begin
            stall_cnt_r <= CNT_ZERO;
            flush_cnt_r <= CNT_ZERO;
            mem_err_r   <= 1'b0;
        end else begin
            if ((stall_all_s || stall_fd_s) && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (br_take_s && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
            if (err_set_s) begin
                mem_err_r <= 1'b1;
            end else begin
                mem_err_r <= mem_err_r;
            end
        end
    end

    // Controls are combinational so a stall lands in the same cycle; reset forces them quiet.
    assign ForwardAE = rst ? fwd_a_s : FWD_RF;
    assign ForwardBE = rst ? fwd_b_s : FWD_RF;
    assign StallF    = rst & (stall_all_s | stall_fd_s);
    assign StallD    = rst & (stall_all_s | stall_fd_s);
    assign StallE    = rst & stall_all_s;
    assign StallM    = rst & stall_all_s;
    assign FlushD    = rst & flush_d_s;
    assign FlushE    = rst & flush_e_s;
    assign FlushW    = rst & stall_all_s;
    assign mem_err   = mem_err_r;
    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: vector table, hand-written corner sequences and randomized model comparison.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W;
    logic       RegWriteE, PCSrcE, RegWriteM, MemReqM, MemReadyM, RegWriteW, cnt_clr;
    logic [1:0] ResultSrcE;

    logic [1:0]  fa_a, fb_a, fa_b, fb_b;
    logic        sf_a, sd_a, se_a, sm_a, fd_a, fe_a, fw_a, err_a;
    logic        sf_b, sd_b, se_b, sm_b, fd_b, fe_b, fw_b, err_b;
    logic [31:0] scnt_a, fcnt_a, scnt_b, fcnt_b;
    logic [10:0] obs_a, obs_b;

    assign obs_a = {fa_a, fb_a, sf_a, sd_a, se_a, sm_a, fd_a, fe_a, fw_a};
    assign obs_b = {fa_b, fb_b, sf_b, sd_b, se_b, sm_b, fd_b, fe_b, fw_b};

    hazard_ctrl #(.BR_PENALTY(0), .MEM_TIMEOUT(255), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E),
        .RD_E(RD_E), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .RD_M(RD_M), .RegWriteM(RegWriteM), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .RD_W(RD_W), .RegWriteW(RegWriteW), .cnt_clr(cnt_clr),
        .ForwardAE(fa_a), .ForwardBE(fb_a), .StallF(sf_a), .StallD(sd_a), .StallE(se_a),
        .StallM(sm_a), .FlushD(fd_a), .FlushE(fe_a), .FlushW(fw_a), .mem_err(err_a),
        .stall_cnt(scnt_a), .flush_cnt(fcnt_a)
    );

    hazard_ctrl #(.BR_PENALTY(2), .MEM_TIMEOUT(3), .CNT_W(32)) dut_b (
        .clk(clk), .rst(rst), .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E),
        .RD_E(RD_E), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .RD_M(RD_M), .RegWriteM(RegWriteM), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .RD_W(RD_W), .RegWriteW(RegWriteW), .cnt_clr(cnt_clr),
        .ForwardAE(fa_b), .ForwardBE(fb_b), .StallF(sf_b), .StallD(sd_b), .StallE(se_b),
        .StallM(sm_b), .FlushD(fd_b), .FlushE(fe_b), .FlushW(fw_b), .mem_err(err_b),
        .stall_cnt(scnt_b), .flush_cnt(fcnt_b)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: index 0 = dut_a, 1 = dut_b.
    int     bp [2] = '{0, 2};
    int     mt [2] = '{255, 3};
    bit     busy [2];
    int     wlen [2];
    int     pen  [2];
    bit     err  [2];
    longint scnt [2];
    longint fcnt [2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            busy[i] = 1'b0; wlen[i] = 0; pen[i] = 0; err[i] = 1'b0; scnt[i] = 0; fcnt[i] = 0;
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (RegWriteM && RD_M != 5'd0 && RD_M == rs) return 2'b10;
        if (RegWriteW && RD_W != 5'd0 && RD_W == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_step(input int i, output logic [10:0] e);
        bit mw = MemReqM && !MemReadyM;
        bit lw = (ResultSrcE == 2'b01) && (RD_E != 5'd0) && (RD_E == RS1_D || RD_E == RS2_D);
        bit sf = 0, sd = 0, se = 0, sm = 0, fd = 0, fe = 0, fw = 0, eset = 0;
        if (busy[i] && !mw) begin
            busy[i] = 1'b0;
            wlen[i] = 0;
        end else if (mw) begin
            sf = 1; sd = 1; se = 1; sm = 1; fw = 1;
            wlen[i] = busy[i] ? wlen[i] + 1 : 1;
            busy[i] = 1'b1;
            pen[i]  = 0;
            eset    = (wlen[i] >= mt[i]);
        end else if (PCSrcE) begin
            fd = 1; fe = 1;
            fcnt[i]++;
            pen[i] = bp[i];
        end else if (pen[i] > 0) begin
            fd = 1;
            pen[i]--;
        end else if (lw) begin
            sf = 1; sd = 1; fe = 1;
        end
        if (sf) scnt[i]++;
        if (cnt_clr) begin
            scnt[i] = 0; fcnt[i] = 0; err[i] = 1'b0;
        end else if (eset) begin
            err[i] = 1'b1;
        end
        e = {ref_fwd(RS1_E), ref_fwd(RS2_E), sf, sd, se, sm, fd, fe, fw};
    endtask

    // Wait for the mid-cycle sample point, compare both DUTs with the model, advance the model.
    task automatic at_neg();
        logic [10:0] ea, eb;
        @(negedge clk);
        check("stall_cnt_a", scnt_a, scnt[0]);
        check("flush_cnt_a", fcnt_a, fcnt[0]);
        check("mem_err_a",   err_a,  err[0]);
        check("stall_cnt_b", scnt_b, scnt[1]);
        check("flush_cnt_b", fcnt_b, fcnt[1]);
        check("mem_err_b",   err_b,  err[1]);
        model_step(0, ea);
        model_step(1, eb);
        check("outs_a", obs_a, ea);
        check("outs_b", obs_b, eb);
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        RS1_D = 5'd0; RS2_D = 5'd0; RS1_E = 5'd0; RS2_E = 5'd0; RD_E = 5'd0;
        RD_M = 5'd0; RD_W = 5'd0; RegWriteE = 1'b0; ResultSrcE = 2'b00; PCSrcE = 1'b0;
        RegWriteM = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b1; RegWriteW = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_outs_a", obs_a, 11'd0);
        check("rst_outs_b", obs_b, 11'd0);
        check("rst_cnt_b", {scnt_b, fcnt_b}, 64'd0);
        check("rst_err", {err_a, err_b}, 2'b00);
        rst = 1'b1;
        model_reset();
        to_next();
    endtask

    typedef struct {
        logic [4:0] rs1e, rs2e, rdm; logic wm; logic [4:0] rdw; logic ww;
        logic [1:0] rse; logic [4:0] rde, rs1d, rs2d; logic pc;
        logic [1:0] fa, fb; logic [3:0] flg;   // flg = {StallF, StallD, FlushD, FlushE}
    } vec_t;

    vec_t vt [10];

    initial begin
        vt[0] = '{5'd5, 5'd0, 5'd5, 1'b1, 5'd5, 1'b1, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 2'b10, 2'b00, 4'b0000};
        vt[1] = '{5'd5, 5'd0, 5'd0, 1'b1, 5'd5, 1'b1, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 2'b01, 2'b00, 4'b0000};
        vt[2] = '{5'd3, 5'd3, 5'd3, 1'b0, 5'd3, 1'b1, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 2'b01, 2'b01, 4'b0000};
        vt[3] = '{5'd4, 5'd9, 5'd9, 1'b1, 5'd4, 1'b1, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 2'b01, 2'b10, 4'b0000};
        vt[4] = '{5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 2'b00, 4'b0000};
        vt[5] = '{5'd1, 5'd2, 5'd0, 1'b0, 5'd0, 1'b0, 2'b01, 5'd7, 5'd1, 5'd7, 1'b0, 2'b00, 2'b00, 4'b1101};
        vt[6] = '{5'd1, 5'd2, 5'd0, 1'b0, 5'd0, 1'b0, 2'b10, 5'd7, 5'd1, 5'd7, 1'b0, 2'b00, 2'b00, 4'b0000};
        vt[7] = '{5'd1, 5'd2, 5'd0, 1'b0, 5'd0, 1'b0, 2'b01, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 2'b00, 4'b0000};
        vt[8] = '{5'd1, 5'd2, 5'd0, 1'b0, 5'd0, 1'b0, 2'b01, 5'd7, 5'd7, 5'd3, 1'b1, 2'b00, 2'b00, 4'b0011};
        vt[9] = '{5'd6, 5'd6, 5'd6, 1'b1, 5'd2, 1'b1, 2'b00, 5'd0, 5'd0, 5'd0, 1'b1, 2'b10, 2'b10, 4'b0011};

        do_reset();

        // Table vectors against dut_a from RUN.
        for (int k = 0; k < 10; k++) begin
            idle();
            RS1_E = vt[k].rs1e; RS2_E = vt[k].rs2e; RD_M = vt[k].rdm; RegWriteM = vt[k].wm;
            RD_W = vt[k].rdw; RegWriteW = vt[k].ww; ResultSrcE = vt[k].rse; RD_E = vt[k].rde;
            RS1_D = vt[k].rs1d; RS2_D = vt[k].rs2d; PCSrcE = vt[k].pc;
            at_neg();
            check($sformatf("vec%0d_fwd", k), {fa_a, fb_a}, {vt[k].fa, vt[k].fb});
            check($sformatf("vec%0d_flags", k), {sf_a, sd_a, fd_a, fe_a}, vt[k].flg);
            to_next();
        end

        // Load-use: one stall cycle, then the bubble removes the hazard.
        do_reset();
        idle(); ResultSrcE = 2'b01; RD_E = 5'd7; RS2_D = 5'd7;
        at_neg();
        check("lu_stall", {sf_a, sd_a, fe_a}, 3'b111);
        to_next();
        idle(); RS2_D = 5'd7;
        at_neg();
        check("lu_release", {sf_a, sd_a, fe_a}, 3'b000);
        check("lu_stall_cnt", scnt_a, 32'd1);
        to_next();

        // Load-use with a same-cycle taken branch: branch wins, no stall.
        do_reset();
        idle(); ResultSrcE = 2'b01; RD_E = 5'd7; RS2_D = 5'd7; PCSrcE = 1'b1;
        at_neg();
        check("lubr_flush", {fd_a, fe_a, sf_a}, 3'b110);
        to_next();
        idle();
        at_neg();
        check("lubr_flush_cnt", fcnt_a, 32'd1);
        to_next();

        // Branch penalty of 2 on dut_b.
        do_reset();
        idle(); PCSrcE = 1'b1;
        at_neg();
        check("bp_c0", {fd_b, fe_b}, 2'b11);
        to_next();
        idle();
        for (int c = 1; c <= 3; c++) begin
            at_neg();
            check($sformatf("bp_c%0d", c), {fd_b, fe_b}, (c < 3) ? 2'b10 : 2'b00);
            to_next();
        end

        // Four-cycle memory wait on dut_a: no timeout.
        do_reset();
        idle(); MemReqM = 1'b1; MemReadyM = 1'b0;
        for (int c = 0; c < 4; c++) begin
            at_neg();
            check($sformatf("mw_c%0d", c), {sf_a, sd_a, se_a, sm_a, fw_a}, 5'b11111);
            to_next();
        end
        MemReadyM = 1'b1;
        at_neg();
        check("mw_ready", {sf_a, sd_a, se_a, sm_a, fw_a}, 5'b00000);
        to_next();
        idle();
        at_neg();
        check("mw_no_err", err_a, 1'b0);
        to_next();

        // Timeout of 3 on dut_b, then cnt_clr, then async reset mid-wait.
        do_reset();
        idle(); MemReqM = 1'b1; MemReadyM = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            at_neg();
            check($sformatf("to_err_c%0d", c), err_b, (c >= 4) ? 1'b1 : 1'b0);
            check($sformatf("to_stall_c%0d", c), sm_b, 1'b1);
            to_next();
        end
        MemReadyM = 1'b1;
        at_neg();
        to_next();
        idle();
        at_neg();
        check("to_sticky", err_b, 1'b1);
        to_next();
        cnt_clr = 1'b1;
        at_neg();
        to_next();
        idle();
        at_neg();
        check("to_clr", {err_b, scnt_b}, 33'd0);
        to_next();
        MemReqM = 1'b1; MemReadyM = 1'b0; RegWriteM = 1'b1; RD_M = 5'd4; RS1_E = 5'd4;
        at_neg();
        to_next();
        at_neg();
        #2 rst = 1'b0;
        #1;
        check("arst_outs_a", obs_a, 11'd0);
        check("arst_outs_b", obs_b, 11'd0);
        check("arst_cnt", {scnt_a, scnt_b}, 64'd0);
        do_reset();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            RS1_D = 5'($urandom_range(0, 3)); RS2_D = 5'($urandom_range(0, 3));
            RS1_E = 5'($urandom_range(0, 3)); RS2_E = 5'($urandom_range(0, 3));
            RD_E  = 5'($urandom_range(0, 3)); RD_M  = 5'($urandom_range(0, 3));
            RD_W  = 5'($urandom_range(0, 3));
            RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
            ResultSrcE = 2'($urandom);
            PCSrcE    = ($urandom_range(0, 5) == 0);
            MemReqM   = ($urandom_range(0, 2) == 0);
            MemReadyM = ($urandom_range(0, 1) == 0);
            cnt_clr   = ($urandom_range(0, 59) == 0);
            at_neg();
            to_next();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage RV32 core (F/D/E/M/W).
- Generates operand-forwarding selects for the E stage.
- Generates stall/flush enables for the F/D, D/E, E/M and M/W pipeline registers, covering load-use stalls, taken-branch redirects with a configurable fetch penalty, and data-memory wait states with a watchdog.
- Keeps saturating stall/flush event counters for performance monitoring.

Parameters:
- BR_PENALTY, 0: extra cycles FlushD stays asserted after a taken branch (0..7).
- MEM_TIMEOUT, 255: consecutive memory wait cycles before mem_err is raised.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- RS1_D, RS2_D  in  5  source register addresses of the instruction in D
- RS1_E, RS2_E, RD_E  in  5  register addresses held in the D/E register
- RegWriteE  in  1  E-stage register write enable
- ResultSrcE  in  2  00 ALU, 01 load, 10 PC+4
- PCSrcE  in  1  taken branch/jump resolved in E
- RD_M  in  5  M-stage destination register
- RegWriteM  in  1  M-stage register write enable
- MemReqM  in  1  M stage is issuing a load or store
- MemReadyM  in  1  data memory completes the access this cycle
- RD_W  in  5  W-stage destination register
- RegWriteW  in  1  W-stage register write enable
- cnt_clr  in  1  synchronous clear of the counters and mem_err
- ForwardAE, ForwardBE  out  2  00 register file, 01 ResultW, 10 ALUResultM
- StallF, StallD, StallE, StallM  out  1  hold the PC and the F/D, D/E, E/M registers
- FlushD, FlushE, FlushW  out  1  bubble into F/D, D/E and M/W
- mem_err  out  1  sticky memory-timeout flag
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

Behaviour:
- Reset: FSM goes to RUN. All counters, the penalty counter, the wait counter and mem_err are cleared. All stall/flush outputs are 0. Forward selects are 00.
- Forwarding (combinational):
  - ForwardAE = 10 if RegWriteM and RD_M != 0 and RD_M == RS1_E.
  - Otherwise 01 if RegWriteW and RD_W != 0 and RD_W == RS1_E.
  - Otherwise 00.
  - M has priority over W. ForwardBE is the same computation using RS2_E.
- Load-use hazard: lw_hz = ResultSrcE == 01 and RD_E != 0 and (RD_E == RS1_D or RD_E == RS2_D).
- Memory wait: mw = MemReqM and not MemReadyM.
- FSM states:
  - RUN:
    - If mw: enter MEM_WAIT. StallF, StallD, StallE and StallM are 1, and FlushW is 1, in this same cycle.
    - Else if PCSrcE: FlushD = FlushE = 1. No stall, even if lw_hz is also true. If BR_PENALTY > 0, load the penalty counter with BR_PENALTY and enter REDIRECT.
    - Else if lw_hz: StallF = StallD = 1 and FlushE = 1 for exactly one cycle.
  - MEM_WAIT:
    - While mw, hold all four stalls and FlushW. Increment the wait counter.
    - A pending PCSrcE or lw_hz is not acted on; it is re-evaluated in the cycle after release.
    - When MemReadyM rises, stalls drop combinationally in that cycle, the wait counter clears, and the FSM returns to RUN.
    - When the wait counter reaches MEM_TIMEOUT, mem_err sets and stays set until cnt_clr or reset. The stall continues regardless.
  - REDIRECT:
    - FlushD = 1 each cycle. The penalty counter decrements and the FSM returns to RUN when it reaches 0.
    - A new PCSrcE reloads the counter.
    - mw preempts: go to MEM_WAIT and discard the remaining penalty.
- Counters:
  - stall_cnt increments on every cycle with StallF = 1.
  - flush_cnt increments on every cycle with PCSrcE accepted in RUN or REDIRECT.
  - Both saturate at all-ones.
  - cnt_clr has priority over increment.
- Reset asserted mid-wait or mid-redirect aborts immediately to the reset state.

Decomposition:
- Shared package holds:
  - ResultSrc encodings: RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10.
  - Forward encodings: FWD_RF, FWD_W, FWD_M.
  - The FSM state enum.
- Sub-module forward_unit: purely combinational, instantiated once and handling both A and B operands.
- The FSM, counters and stall/flush logic stay in hazard_ctrl.

Test Plan:
- RegWriteM = 1, RD_M = 5, RS1_E = 5, and RegWriteW = 1, RD_W = 5 -> ForwardAE = 10. With RD_M = 0 -> ForwardAE = 01. With RS2_E = 0 -> ForwardBE = 00.
- ResultSrcE = 01, RD_E = 7, RS2_D = 7 -> StallF = StallD = FlushE = 1 for exactly one cycle, and stall_cnt becomes 1.
- Same load-use condition with PCSrcE = 1 in the same cycle -> FlushD = FlushE = 1, StallF = 0, flush_cnt becomes 1.
- BR_PENALTY = 2, PCSrcE pulse -> FlushD high for 3 consecutive cycles, FlushE high for the first cycle only.
- MemReqM = 1 with MemReadyM low for 4 cycles -> all stalls and FlushW high for 4 cycles, low in the ready cycle, and mem_err stays 0.
- MEM_TIMEOUT = 3, MemReadyM held low for 10 cycles -> mem_err rises after the 3rd wait cycle and stays high until cnt_clr. Async rst low mid-wait -> all outputs 0 immediately.
